// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver.
// State enum, frame width and the smallest usable clocks-per-bit.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// uart_rx_sync_fifo: first-word-fall-through FIFO, power-of-two depth.
// Push at full is ignored unless a pop happens in the same cycle.
module uart_rx_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign count    = cnt;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                cnt <= cnt + (AW+1)'(1);
            else if (do_pop && !do_push)
                cnt <= cnt - (AW+1)'(1);
        end
    end

    // Storage array, no reset needed: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a FWFT receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit and parity_err_o.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx_i,
    input  logic [DIV_W-1:0]             div_i,
    input  logic                         rx_en_i,
    output logic [7:0]                   data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(FIFO_DEPTH):0]  count_o,
    output logic                         overrun_o,
    output logic                         frame_err_o,
    input  logic                         clr_err_i,
`ifdef UART_RX_PARITY_EN
    input  logic                         parity_odd_i,
    output logic                         parity_err_o,
`endif
    output logic                         busy_o
);

    state_t           state;
    state_t           state_n;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_q;
    logic             rx_fall;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] limit;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             tick;
    logic             start;
    logic             shift_en;
    logic             push;
    logic             frame_set;
    logic             ovr_set;
    logic             fifo_full;
    logic             fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic             par_odd_q;
    logic             par_set;
`endif

    assign rx_fall = rx_q & ~rx_s2;
    assign limit   = (state == START) ? (div_q >> 1) - DIV_W'(1)
                                      : div_q - DIV_W'(1);
    assign tick    = (cnt == limit);
    assign busy_o  = (state != IDLE);
    assign valid_o = ~fifo_empty;
    assign ovr_set = push & fifo_full & ~ready_i;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_n   = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (rx_en_i && rx_fall) begin
                    state_n = START;
                    start   = 1'b1;
                end
            end
            START: begin
                if (tick) state_n = rx_s2 ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'(DATA_BITS-1))
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_set = (rx_s2 != (^shreg ^ par_odd_q));
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rx_s2) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_n   = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s2) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Bit timer, divisor capture and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            div_q   <= DIV_W'(MIN_DIV);
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_odd_q <= 1'b0;
`endif
        end else if (start) begin
            cnt     <= '0;
            bit_cnt <= '0;
            div_q   <= (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;
`ifdef UART_RX_PARITY_EN
            par_odd_q <= parity_odd_i;
`endif
        end else if (state != IDLE) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
            if (shift_en) begin
                shreg   <= {rx_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else begin
            overrun_o   <= ovr_set | (overrun_o & ~clr_err_i);
            frame_err_o <= frame_set | (frame_err_o & ~clr_err_i);
`ifdef UART_RX_PARITY_EN
            parity_err_o <= par_set | (parity_err_o & ~clr_err_i);
`endif
        end
    end

    uart_rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (ready_i),
        .pop_data  (data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count_o)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized self-checking bench for uart_rx_fifo.
// Frames are built bit by bit; a byte queue models the receive FIFO.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_i;
    logic [15:0]   div_i;
    logic          rx_en_i;
    logic [7:0]    data_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] count_o;
    logic          overrun_o;
    logic          frame_err_o;
    logic          clr_err_i;
    logic          busy_o;
`ifdef UART_RX_PARITY_EN
    logic          parity_odd_i;
    logic          parity_err_o;
`endif

    uart_rx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .div_i        (div_i),
        .rx_en_i      (rx_en_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .count_o      (count_o),
        .overrun_o    (overrun_o),
        .frame_err_o  (frame_err_o),
        .clr_err_i    (clr_err_i),
`ifdef UART_RX_PARITY_EN
        .parity_odd_i (parity_odd_i),
        .parity_err_o (parity_err_o),
`endif
        .busy_o       (busy_o)
    );

    always #20 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q[$];
    logic       ov_m = 1'b0;
    logic       fe_m = 1'b0;
    logic       pe_m = 1'b0;
    int         pop_at = -1;
    logic       scramble = 1'b0;
    int         en_off_at = -1;
    int         rise_c;
    logic       fe_seen;
    logic       snap_busy;
    logic       snap_fe;
    int         snap_cnt;

    // One complete frame, one clock per iteration, sampled at negedge.
    task automatic send_frame(input logic [7:0] b, input int bc,
                              input int stop_low, input logic par_flip);
        int   total;
        int   idx;
        logic en_start;
        logic lvl;
        logic pbit;
        en_start = rx_en_i;
        total    = (STOP_IDX + stop_low + 1) * bc;
        div_i    = 16'(bc);
`ifdef UART_RX_PARITY_EN
        pbit = ^b ^ parity_odd_i ^ par_flip;
`else
        pbit = ~par_flip;
`endif
        rise_c  = -1;
        fe_seen = 1'b0;
        for (int c = 0; c < total; c++) begin
            if (rise_c < 0 && valid_o === 1'b1) rise_c = c;
            if (frame_err_o === 1'b1) fe_seen = 1'b1;
            if (c == (STOP_IDX + stop_low) * bc - 1) begin
                snap_busy = busy_o;
                snap_fe   = frame_err_o;
                snap_cnt  = int'(count_o);
            end
            if (c == pop_at) begin
                ready_i = 1'b1;
                if (q.size() > 0) q.delete(0);
            end else begin
                ready_i = 1'b0;
            end
            if (c == bc && scramble) div_i = 16'($urandom_range(4, 300));
            if (c == en_off_at) rx_en_i = 1'b0;
            idx = c / bc;
            if (idx == 0)                        lvl = 1'b0;
            else if (idx <= 8)                   lvl = b[idx-1];
            else if (idx < STOP_IDX)             lvl = pbit;
            else if (idx < STOP_IDX + stop_low)  lvl = 1'b0;
            else                                 lvl = 1'b1;
            rx_i = lvl;
            @(negedge clk);
        end
        ready_i = 1'b0;
        div_i   = 16'(bc);
        if (en_off_at >= 0) rx_en_i = 1'b1;
        en_off_at = -1;
        pop_at    = -1;
        scramble  = 1'b0;
        if (en_start) begin
            if (stop_low > 0) fe_m = 1'b1;
            else if (q.size() < DEPTH) q.push_back(b);
            else ov_m = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_flip) pe_m = 1'b1;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_i = 1'b1; rx_en_i = 1'b1; ready_i = 1'b0;
        clr_err_i = 1'b0; div_i = 16'd32;
`ifdef UART_RX_PARITY_EN
        parity_odd_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_cmp++;
        if (valid_o !== 1'b0 || count_o !== '0 || data_o !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_fifo: valid=%b count=%0d data=%h want 0/0/00",
                     valid_o, count_o, data_o);
        end
        n_cmp++;
        if (overrun_o !== 1'b0 || frame_err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: ovr=%b fe=%b busy=%b want 0/0/0",
                     overrun_o, frame_err_o, busy_o);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: busy=%b valid=%b want 0/0",
                     busy_o, valid_o);
        end
    endtask

    task automatic test_single();
        int lat;
        lat = 3 + 32 / 2 + STOP_IDX * 32;
        send_frame(8'hA5, 32, 0, 1'b0);
        n_cmp++;
        if (rise_c != lat) begin
            n_bad++;
            $display("FAIL push_latency: valid rose at %0d want %0d", rise_c, lat);
        end
        n_cmp++;
        if (valid_o !== 1'b1 || data_o !== 8'hA5 || count_o !== CW'(1)) begin
            n_bad++;
            $display("FAIL single_byte: valid=%b data=%h count=%0d want 1/a5/1",
                     valid_o, data_o, count_o);
        end
        n_cmp++;
        if (overrun_o !== 1'b0 || frame_err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_flags: ovr=%b fe=%b busy=%b want 0/0/0",
                     overrun_o, frame_err_o, busy_o);
        end
        while (q.size() > 0) begin
            ready_i = 1'b1; @(negedge clk); ready_i = 1'b0; q.delete(0);
        end
        n_cmp++;
        if (valid_o !== 1'b0 || count_o !== '0) begin
            n_bad++;
            $display("FAIL single_pop: valid=%b count=%0d want 0/0", valid_o, count_o);
        end
    endtask

    task automatic test_div_hold();
        int         bc;
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            bc = (i == 0) ? 32 : $urandom_range(6, 48);
            b  = 8'($urandom);
            scramble = 1'b1;
            send_frame(b, bc, 0, 1'b0);
            n_cmp++;
            if (valid_o !== 1'b1 || data_o !== q[0]) begin
                n_bad++;
                $display("FAIL div_hold: div=%0d data=%h want %h", bc, data_o, q[0]);
            end
            ready_i = 1'b1; @(negedge clk); ready_i = 1'b0; q.delete(0);
        end
    endtask

    task automatic test_glitch();
        rx_i = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_start: busy=%b want 1", busy_o);
        end
        repeat (4) @(negedge clk);
        rx_i = 1'b1;
        repeat (64) @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || count_o !== '0 ||
            frame_err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_reject: busy=%b valid=%b count=%0d fe=%b want 0/0/0/0",
                     busy_o, valid_o, count_o, frame_err_o);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 32, 2, 1'b0);
        n_cmp++;
        if (snap_busy !== 1'b1 || snap_fe !== 1'b1 || snap_cnt != 0) begin
            n_bad++;
            $display("FAIL frame_break: busy=%b fe=%b count=%0d want 1/1/0",
                     snap_busy, snap_fe, snap_cnt);
        end
        n_cmp++;
        if (busy_o !== 1'b0 || count_o !== '0 || frame_err_o !== fe_m) begin
            n_bad++;
            $display("FAIL frame_recover: busy=%b count=%0d fe=%b want 0/0/%b",
                     busy_o, count_o, frame_err_o, fe_m);
        end
        send_frame(8'h55, 32, 0, 1'b0);
        n_cmp++;
        if (data_o !== 8'h55 || count_o !== CW'(1) || frame_err_o !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_next: data=%h count=%0d fe=%b want 55/1/1",
                     data_o, count_o, frame_err_o);
        end
        ready_i = 1'b1; @(negedge clk); ready_i = 1'b0; q.delete(0);
        clr_err_i = 1'b1; @(negedge clk); clr_err_i = 1'b0; fe_m = 1'b0;
        n_cmp++;
        if (frame_err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_clear: fe=%b want 0", frame_err_o);
        end
        clr_err_i = 1'b1;
        send_frame(8'($urandom), 32, 1, 1'b0);
        clr_err_i = 1'b0; fe_m = 1'b0;
        n_cmp++;
        if (fe_seen !== 1'b1 || frame_err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL set_wins: seen=%b fe=%b want 1/0", fe_seen, frame_err_o);
        end
    endtask

    task automatic test_overrun();
        ready_i = 1'b0;
        for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 32, 0, 1'b0);
        n_cmp++;
        if (count_o !== CW'(DEPTH) || overrun_o !== ov_m || ov_m !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_full: count=%0d ovr=%b want %0d/1",
                     count_o, overrun_o, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (valid_o !== 1'b1 || data_o !== q[0] || data_o !== 8'(i)) begin
                n_bad++;
                $display("FAIL overrun_pop%0d: data=%h want %h", i, data_o, q[0]);
            end
            ready_i = 1'b1; @(negedge clk); ready_i = 1'b0; q.delete(0);
        end
        clr_err_i = 1'b1; @(negedge clk); clr_err_i = 1'b0; ov_m = 1'b0;
        n_cmp++;
        if (overrun_o !== 1'b0 || count_o !== '0) begin
            n_bad++;
            $display("FAIL overrun_clear: ovr=%b count=%0d want 0/0", overrun_o, count_o);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 32, 0, 1'b0);
        pop_at = 3 + 32 / 2 + STOP_IDX * 32 - 1;
        send_frame(8'($urandom), 32, 0, 1'b0);
        n_cmp++;
        if (count_o !== CW'(DEPTH) || overrun_o !== 1'b0 || ov_m !== 1'b0) begin
            n_bad++;
            $display("FAIL full_push_pop: count=%0d ovr=%b want %0d/0",
                     count_o, overrun_o, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (valid_o !== 1'b1 || data_o !== q[0]) begin
                n_bad++;
                $display("FAIL full_order%0d: data=%h want %h", i, data_o, q[0]);
            end
            ready_i = 1'b1; @(negedge clk); ready_i = 1'b0; q.delete(0);
        end
    endtask

    task automatic test_rx_en();
        rx_en_i = 1'b0;
        send_frame(8'($urandom), 32, 0, 1'b0);
        rx_en_i = 1'b1;
        n_cmp++;
        if (count_o !== '0 || valid_o !== 1'b0 || snap_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_disabled: count=%0d valid=%b busy=%b want 0/0/0",
                     count_o, valid_o, snap_busy);
        end
        en_off_at = 3 * 32;
        send_frame(8'($urandom), 32, 0, 1'b0);
        n_cmp++;
        if (count_o !== CW'(1) || data_o !== q[0]) begin
            n_bad++;
            $display("FAIL rx_en_midframe: count=%0d data=%h want 1/%h",
                     count_o, data_o, q[0]);
        end
        ready_i = 1'b1; @(negedge clk); ready_i = 1'b0; q.delete(0);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        parity_odd_i = 1'b0;
        send_frame(8'h01, 32, 0, 1'b1);
        n_cmp++;
        if (parity_err_o !== 1'b1 || data_o !== 8'h01 || count_o !== CW'(1)) begin
            n_bad++;
            $display("FAIL parity_bad: perr=%b data=%h count=%0d want 1/01/1",
                     parity_err_o, data_o, count_o);
        end
        ready_i = 1'b1; @(negedge clk); ready_i = 1'b0; q.delete(0);
        clr_err_i = 1'b1; @(negedge clk); clr_err_i = 1'b0; pe_m = 1'b0;
        parity_odd_i = 1'b1;
        send_frame(8'($urandom), 32, 0, 1'b0);
        n_cmp++;
        if (parity_err_o !== 1'b0 || data_o !== q[0]) begin
            n_bad++;
            $display("FAIL parity_odd_ok: perr=%b data=%h want 0/%h",
                     parity_err_o, data_o, q[0]);
        end
        ready_i = 1'b1; @(negedge clk); ready_i = 1'b0; q.delete(0);
    endtask
`endif

    task automatic test_random();
        int   bc;
        int   sl;
        int   np;
        for (int f = 0; f < 16; f++) begin
            bc = $urandom_range(6, 40);
            sl = ($urandom_range(0, 5) == 0) ? 1 : 0;
            send_frame(8'($urandom), bc, sl, 1'($urandom_range(0, 1)));
            n_cmp++;
            if (count_o !== CW'(q.size()) || overrun_o !== ov_m ||
                frame_err_o !== fe_m || valid_o !== (q.size() > 0)) begin
                n_bad++;
                $display("FAIL rand%0d_state: count=%0d ovr=%b fe=%b want %0d/%b/%b",
                         f, count_o, overrun_o, frame_err_o, q.size(), ov_m, fe_m);
            end
`ifdef UART_RX_PARITY_EN
            n_cmp++;
            if (parity_err_o !== pe_m) begin
                n_bad++;
                $display("FAIL rand%0d_parity: perr=%b want %b", f, parity_err_o, pe_m);
            end
`endif
            np = $urandom_range(0, q.size());
            for (int i = 0; i < np; i++) begin
                n_cmp++;
                if (valid_o !== 1'b1 || data_o !== q[0]) begin
                    n_bad++;
                    $display("FAIL rand%0d_pop: data=%h want %h", f, data_o, q[0]);
                end
                ready_i = 1'b1; @(negedge clk); ready_i = 1'b0; q.delete(0);
            end
            if ($urandom_range(0, 3) == 0) begin
                clr_err_i = 1'b1; @(negedge clk); clr_err_i = 1'b0;
                ov_m = 1'b0; fe_m = 1'b0; pe_m = 1'b0;
            end
        end
    endtask

    initial begin
        #(40 * 95000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_div_hold();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
        test_rx_en();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
